// File: rtl/ntt_bitrev_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module : ntt_pkg
// Brief  : Shared bank state encoding and index bit-reversal helper.
// Rev    : 1.0
// ============================================================================
package ntt_pkg;

    localparam int c_MAX_LOG_N = 10;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    // Reverse the full maximum-width index, then shift down so that only the
    // low log_n bits end up reversed among themselves.
    function automatic logic [c_MAX_LOG_N-1:0] bitrev(input logic [c_MAX_LOG_N-1:0] idx,
                                                      input int log_n);
        logic [c_MAX_LOG_N-1:0] r;
        for (int i = 0; i < c_MAX_LOG_N; i++) begin
            r[i] = idx[c_MAX_LOG_N-1-i];
        end
        return r >> (c_MAX_LOG_N - log_n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_bitrev_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ntt_bitrev_bank_ctrl
// Brief  : Per-bank lifecycle state plus the output-order mode latched at fill start.
// Rev    : 1.0
// ============================================================================
module ntt_bitrev_bank_ctrl
    import ntt_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wr_first,
    input  logic        i_wr_last,
    input  logic        i_cfg_mode,
    input  logic        i_rd_first,
    input  logic        i_rd_last,
    output bank_state_e o_state,
    output logic        o_mode
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_state <= EMPTY;
            o_mode  <= 1'b0;
        end else begin
            case (o_state)
                EMPTY: begin
                    if (i_wr_first) begin
                        o_state <= FILLING;
                        o_mode  <= i_cfg_mode;
                    end
                end
                FILLING:  if (i_wr_last)  o_state <= FULL;
                FULL:     if (i_rd_first) o_state <= DRAINING;
                DRAINING: if (i_rd_last)  o_state <= EMPTY;
                default:  o_state <= EMPTY;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ntt_bitrev_stream.sv
`default_nettype none
// ============================================================================
// Module : ntt_bitrev_stream
// Brief  : Ping-pong frame buffer emitting N-word frames in bit-reversed or natural order.
// Rev    : 1.0
// ============================================================================
module ntt_bitrev_stream
    import ntt_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LOG_N  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_bitrev,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_err
);

    localparam int               c_N    = 1 << LOG_N;
    localparam logic [LOG_N-1:0] c_LAST = '1;

    logic [DATA_W-1:0] r_mem [2][c_N];
    logic              r_in_en;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [LOG_N-1:0]  r_wr_cnt;
    logic [LOG_N-1:0]  r_rd_cnt;

    bank_state_e       w_state [2];
    logic              w_mode  [2];
    logic              w_wr_fire;
    logic              w_wr_end;
    logic              w_rd_end;
    logic              w_load;
    logic [LOG_N-1:0]  w_rd_idx;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        ntt_bitrev_bank_ctrl u_ctrl (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_wr_first (w_wr_fire && (r_wr_bank == 1'(b)) && (r_wr_cnt == '0)),
            .i_wr_last  (w_wr_fire && (r_wr_bank == 1'(b)) && w_wr_end),
            .i_cfg_mode (cfg_bitrev),
            .i_rd_first (w_load && (r_rd_bank == 1'(b)) && (r_rd_cnt == '0)),
            .i_rd_last  (w_load && (r_rd_bank == 1'(b)) && w_rd_end),
            .o_state    (w_state[b]),
            .o_mode     (w_mode[b])
        );
    end

    // r_in_en keeps in_ready low through reset and for the release cycle.
    assign in_ready  = r_in_en && ((w_state[r_wr_bank] == EMPTY) ||
                                   (w_state[r_wr_bank] == FILLING));
    assign w_wr_fire = in_valid && in_ready;
    assign w_wr_end  = (r_wr_cnt == c_LAST);
    assign w_rd_end  = (r_rd_cnt == c_LAST);
    assign w_load    = ((w_state[r_rd_bank] == FULL) || (w_state[r_rd_bank] == DRAINING)) &&
                       (!out_valid || out_ready);
    assign w_rd_idx  = w_mode[r_rd_bank] ?
                       LOG_N'(bitrev(c_MAX_LOG_N'(r_rd_cnt), LOG_N)) : r_rd_cnt;

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_bank][r_wr_cnt] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_en   <= 1'b0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_in_en <= 1'b1;
            if (w_wr_fire) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_wr_end) begin
                    r_wr_bank <= ~r_wr_bank;
                end
                // Frame boundaries come from the count; in_last is only audited.
                if (in_last != w_wr_end) begin
                    frame_err <= 1'b1;
                end
            end
            if (w_load) begin
                out_valid <= 1'b1;
                out_data  <= r_mem[r_rd_bank][w_rd_idx];
                out_last  <= w_rd_end;
                r_rd_cnt  <= r_rd_cnt + 1'b1;
                if (w_rd_end) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ntt_bitrev_stream.sv
`default_nettype none
// ============================================================================
// Module : tb_ntt_bitrev_stream
// Brief  : Randomized and directed bench with a frame-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_ntt_bitrev_stream;

    logic       clk;
    logic       rst_n;
    logic       cfg_bitrev;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_err;

    ntt_bitrev_stream #(.DATA_W(8), .LOG_N(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_bitrev (cfg_bitrev),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_err  (frame_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rmode = 2;

    logic [8:0] exp_q[$];
    logic [8:0] out_log[$];
    logic [7:0] fbuf[8];
    int         fcnt = 0;
    logic       fmode = 1'b0;
    logic       m_err = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;
    int         hs_first = 0;
    int         hs_last  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int brev(input int k, input int n);
        int r = 0;
        for (int b = 0; b < n; b++) r = r * 2 + ((k >> b) & 1);
        return r;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        case (rmode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            2: out_ready = 1'b0;
            default: ;
        endcase
    end

    // Reference model and per-cycle compare; inputs are stable at negedge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            fcnt = 0;
            m_err = 1'b0;
            prev_hold = 1'b0;
        end else begin
            chk("frame_err", frame_err, m_err);
            if (prev_hold) begin
                chk("hold_data", out_data, prev_data);
                chk("hold_last", out_last, prev_last);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", out_valid, 1'b0);
                end else begin
                    chk("out_data", out_data, exp_q[0][7:0]);
                    chk("out_last", out_last, exp_q[0][8]);
                    if (out_ready) begin
                        if (out_log.size() == 0) hs_first = cyc;
                        hs_last = cyc;
                        out_log.push_back({out_last, out_data});
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (in_valid && in_ready) begin
                if (fcnt == 0) fmode = cfg_bitrev;
                fbuf[fcnt] = in_data;
                if (in_last != (fcnt == 7)) m_err = 1'b1;
                fcnt++;
                if (fcnt == 8) begin
                    for (int k = 0; k < 8; k++)
                        exp_q.push_back({(k == 7), fbuf[fmode ? brev(k, 3) : k]});
                    fcnt = 0;
                end
            end
        end
    end

    task automatic put(input logic [7:0] d, input logic l, input logic m);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        cfg_bitrev = m;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 300) begin
                chk("in_ready_timeout", in_ready, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        in_valid = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) break;
            t++;
            if (t > 500) begin
                chk("drain_timeout", exp_q.size(), 0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int base, input logic m, input int last_pos);
        for (int w = 0; w < 8; w++) put(8'(base + w), (w == last_pos), m);
        in_valid = 1'b0;
    endtask

    logic [7:0] e1[8];
    logic [7:0] e6[8];
    int         t0;
    int         acc;

    initial begin
        e1 = '{8'd0, 8'd4, 8'd2, 8'd6, 8'd1, 8'd5, 8'd3, 8'd7};
        e6 = '{8'd10, 8'd14, 8'd12, 8'd16, 8'd11, 8'd15, 8'd13, 8'd17};
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        cfg_bitrev = 1'b0; out_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'd0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_cycle_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("after_release_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rmode = 0;

        // Bit-reversed frame
        out_log.delete();
        send_frame(0, 1'b1, 7);
        wait_drain();
        chk("t1_count", out_log.size(), 8);
        for (int k = 0; k < 8 && k < out_log.size(); k++) begin
            chk("t1_data", out_log[k][7:0], e1[k]);
            chk("t1_last", out_log[k][8], (k == 7));
        end

        // Bypass frame and first-output latency
        out_log.delete();
        for (int w = 0; w < 8; w++) put(8'(w), (w == 7), 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_latency_early", out_valid, 1'b0);
        @(negedge clk);
        chk("t2_latency_valid", out_valid, 1'b1);
        chk("t2_first_data", out_data, 8'd0);
        wait_drain();
        chk("t2_count", out_log.size(), 8);
        for (int k = 0; k < 8 && k < out_log.size(); k++)
            chk("t2_data", out_log[k][7:0], 8'(k));

        // Four back-to-back frames at full rate
        out_log.delete();
        t0 = cyc;
        for (int f = 0; f < 4; f++) begin
            cfg_bitrev = 1'($urandom_range(0, 1));
            for (int w = 0; w < 8; w++) put(8'($urandom), (w == 7), cfg_bitrev);
        end
        in_valid = 1'b0;
        chk("t3_in_cycles", cyc - t0, 32);
        wait_drain();
        chk("t3_out_count", out_log.size(), 32);
        chk("t3_out_span", hs_last - hs_first, 31);

        // Downstream blocked: both banks fill, then random stalls drain
        rmode = 2;
        @(posedge clk); #1;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_data = 8'(8'h40 + acc);
            in_last = ((acc % 8) == 7);
            cfg_bitrev = 1'b1;
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("t4_accepted", acc, 16);
        @(negedge clk);
        chk("t4_in_ready_low", in_ready, 1'b0);
        @(posedge clk); #1;
        rmode = 1;
        wait_drain();

        // Randomized soak: idle gaps, random stalls, cfg changing mid-frame
        for (int f = 0; f < 10; f++) begin
            logic m0;
            m0 = 1'($urandom_range(0, 1));
            for (int w = 0; w < 8; w++) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                put(8'($urandom), (w == 7), (w == 0) ? m0 : 1'($urandom_range(0, 1)));
            end
        end
        wait_drain();
        chk("soak_drained", exp_q.size(), 0);

        // Misplaced in_last
        rmode = 0;
        out_log.delete();
        send_frame(8'h80, 1'b0, 4);
        wait_drain();
        chk("t5_err_set", frame_err, 1'b1);
        chk("t5_count", out_log.size(), 8);
        send_frame(8'h90, 1'b1, 7);
        wait_drain();
        chk("t5_err_sticky", frame_err, 1'b1);

        // Reset in the middle of a drain
        rmode = 2;
        @(posedge clk); #1;
        send_frame(20, 1'b1, 7);
        begin
            int t;
            t = 0;
            while (!out_valid && t < 50) begin @(negedge clk); t++; end
        end
        @(posedge clk); #1;
        rmode = 3;
        out_log.delete();
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        #2;
        chk("t6_words_before_rst", out_log.size(), 3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", out_valid, 1'b0);
        chk("t6_rst_out_data", out_data, 8'd0);
        chk("t6_rst_out_last", out_last, 1'b0);
        chk("t6_rst_frame_err", frame_err, 1'b0);
        chk("t6_rst_in_ready", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rmode = 0;
        @(posedge clk); #1;
        out_log.delete();
        send_frame(10, 1'b1, 7);
        wait_drain();
        chk("t6_count", out_log.size(), 8);
        for (int k = 0; k < 8 && k < out_log.size(); k++) begin
            chk("t6_data", out_log[k][7:0], e6[k]);
            chk("t6_last", out_log[k][8], (k == 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
